divider: RTL and testbench

DIVIDER -- requirements
Module: divider

---
 rtl/divider_pkg.sv | 23 ++
 rtl/divider_step.sv | 26 ++
 rtl/divider.sv | 97 +++++++++
 tb/tb_divider.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/divider_pkg.sv
// Shared ALU definitions: default operand width, function codes and the
// divider state encoding used by the divider and its iteration step.
package divider_pkg;

  localparam int ALU_WIDTH = 32;

  localparam logic [5:0] FUNCT_MULT  = 6'b011000;
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;
  localparam logic [5:0] FUNCT_DIV   = 6'b011010;
  localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;

  // Multiply codes belong to the multiplier unit, never to the divider.
  function automatic logic is_mul_funct(input logic [5:0] funct);
    return (funct == FUNCT_MULT) || (funct == FUNCT_MULTU);
  endfunction

endpackage

// File: rtl/divider_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, then subtract the divisor if it fits.
module div_step
  import divider_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic             i_dividend_msb,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_q_bit
);

  logic [WIDTH:0]   w_shifted;
  logic [WIDTH-1:0] w_diff;

  assign w_shifted = {i_rem, i_dividend_msb};
  assign o_q_bit   = (w_shifted >= {1'b0, i_divisor});

  // Only used when the divisor fits, so the true difference is below the
  // divisor and the dropped top bit cannot matter.
  assign w_diff = w_shifted[WIDTH-1:0] - i_divisor;
  assign o_rem  = o_q_bit ? w_diff : w_shifted[WIDTH-1:0];

endmodule

// File: rtl/divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock,
// result {remainder, quotient} held until the next completion.
module divider
  import divider_pkg::*;
#(
  parameter int         WIDTH      = ALU_WIDTH,
  parameter logic [5:0] DIVU_FUNCT = FUNCT_DIVU
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [5:0]           Signal,
  input  logic [WIDTH-1:0]     dataA,
  input  logic [WIDTH-1:0]     dataB,
  output logic [2*WIDTH-1:0]   dataOut,
  output logic                 busy,
  output logic                 done,
  output logic                 divZero
);

  localparam int CW = $clog2(WIDTH + 1);

  div_state_e r_state, w_state_next;

  logic [WIDTH-1:0]   r_dividend, r_divisor, r_rem, r_quot;
  logic [CW-1:0]      r_count;
  logic [2*WIDTH-1:0] r_data_out;
  logic               r_div_zero;

  logic               w_accept, w_last, w_q_bit;
  logic [WIDTH-1:0]   w_rem_next;

  assign w_accept = start && (Signal == DIVU_FUNCT) && (r_state != RUN);
  assign w_last   = (r_count == CW'(WIDTH - 1));

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem          (r_rem),
    .i_dividend_msb (r_dividend[WIDTH-1]),
    .i_divisor      (r_divisor),
    .o_rem          (w_rem_next),
    .o_q_bit        (w_q_bit)
  );

  always_comb begin
    // NOTE: default assigned first so every path drives w_state_next; no latch.
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_next = RUN;
      RUN:     if (w_last)   w_state_next = DONE;
      DONE:    w_state_next = w_accept ? RUN : IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking so every register samples pre-edge values.
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // Architectural state visible at the ports, cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count    <= '0;
      r_data_out <= '0;
      r_div_zero <= 1'b0;
    end else if (w_accept) begin
      r_count <= '0;
    end else if (r_state == RUN) begin
      r_count <= r_count + 1'b1;
      if (w_last) begin
        r_data_out <= {w_rem_next, r_quot[WIDTH-2:0], w_q_bit};
        r_div_zero <= (r_divisor == '0);
      end
    end
  end

  // NOTE: working registers carry no reset; acceptance always loads them before use.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_dividend <= dataA;
      r_divisor  <= dataB;
      r_rem      <= '0;
      r_quot     <= '0;
    end else if (r_state == RUN) begin
      r_dividend <= {r_dividend[WIDTH-2:0], 1'b0};
      r_rem      <= w_rem_next;
      r_quot     <= {r_quot[WIDTH-2:0], w_q_bit};
    end
  end

  assign dataOut = r_data_out;
  assign busy    = (r_state == RUN);
  assign done    = (r_state == DONE);
  assign divZero = r_div_zero;

endmodule

// File: tb/tb_divider.sv
// Directed bench for the divider: hand-computed quotients/remainders,
// latency, busy length, rejection, reset abort and back-to-back requests.
module tb_divider;
  import divider_pkg::*;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           reset, start;
  logic [5:0]     Signal;
  logic [W-1:0]   dataA, dataB;
  logic [2*W-1:0] dataOut;
  logic           busy, done, divZero;

  int checks   = 0;
  int failures = 0;

  divider #(.WIDTH(W), .DIVU_FUNCT(FUNCT_DIVU)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .Signal  (Signal),
    .dataA   (dataA),
    .dataB   (dataB),
    .dataOut (dataOut),
    .busy    (busy),
    .done    (done),
    .divZero (divZero)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_req(input logic [W-1:0] a, input logic [W-1:0] b, input logic [5:0] fn);
    start  = 1'b1;
    Signal = fn;
    dataA  = a;
    dataB  = b;
    tick();
    start  = 1'b0;
  endtask

  // Called right after the acceptance edge; lat = edges until done (-1 on timeout).
  task automatic wait_done(output int lat, output int bc);
    bc  = int'(busy);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (busy) bc++;
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  initial begin
    int lat, bc, done_seen, changes;

    reset = 1'b1; start = 1'b0; Signal = '0; dataA = '0; dataB = '0;
    tick();
    tick();
    check("rst_busy",    64'(busy),    64'd0);
    check("rst_done",    64'(done),    64'd0);
    check("rst_divzero", 64'(divZero), 64'd0);
    check("rst_dataout", dataOut,      64'd0);
    reset = 1'b0;

    // 100 / 7 = 14 r 2
    start_req(32'd100, 32'd7, FUNCT_DIVU);
    check("busy_after_accept", 64'(busy), 64'd1);
    wait_done(lat, bc);
    check("lat_100_7",  64'(lat), 64'd32);
    check("busy_100_7", 64'(bc),  64'd32);
    check("res_100_7",  dataOut,  {32'd2, 32'd14});
    check("dz_100_7",   64'(divZero), 64'd0);
    tick();
    check("done_falls", 64'(done), 64'd0);
    check("idle_busy",  64'(busy), 64'd0);
    check("idle_hold",  dataOut,   {32'd2, 32'd14});

    start_req(32'hFFFF_FFFF, 32'd1, FUNCT_DIVU);
    wait_done(lat, bc);
    check("res_max_1", dataOut, {32'd0, 32'hFFFF_FFFF});

    start_req(32'd3, 32'd10, FUNCT_DIVU);
    wait_done(lat, bc);
    check("res_3_10", dataOut, {32'd3, 32'd0});

    // Divide by zero: all-ones quotient, remainder = dividend
    start_req(32'd5, 32'd0, FUNCT_DIVU);
    wait_done(lat, bc);
    check("lat_5_0", 64'(lat),     64'd32);
    check("res_5_0", dataOut,      {32'd5, 32'hFFFF_FFFF});
    check("dz_5_0",  64'(divZero), 64'd1);
    tick();
    check("dz_sticky", 64'(divZero), 64'd1);

    // Non-divide function code is ignored
    start = 1'b1; Signal = FUNCT_MULTU; dataA = 32'd9; dataB = 32'd3;
    tick();
    tick();
    check("rej_busy", 64'(busy), 64'd0);
    check("rej_done", 64'(done), 64'd0);
    check("rej_hold", dataOut,   {32'd5, 32'hFFFF_FFFF});
    start = 1'b0;

    // 1000 / 3 = 333 r 1, with a new request attempted mid-run
    start_req(32'd1000, 32'd3, FUNCT_DIVU);
    bc  = int'(busy);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (busy) bc++;
      if (k == 10) begin
        start = 1'b1; Signal = FUNCT_DIVU; dataA = 32'd50; dataB = 32'd5;
      end
      if (k == 13) start = 1'b0;
      if (k == 12) check("midrun_hold", dataOut, {32'd5, 32'hFFFF_FFFF});
      if (done) begin
        lat = k;
        break;
      end
    end
    check("lat_midrun",  64'(lat), 64'd32);
    check("busy_midrun", 64'(bc),  64'd32);
    check("res_1000_3",  dataOut,  {32'd1, 32'd333});
    check("dz_1000_3",   64'(divZero), 64'd0);

    // Reset in the middle of a run abandons it
    start_req(32'd100, 32'd7, FUNCT_DIVU);
    repeat (9) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy",    64'(busy),    64'd0);
    check("abort_dataout", dataOut,      64'd0);
    check("abort_done",    64'(done),    64'd0);
    done_seen = 0;
    repeat (40) begin
      tick();
      if (done) done_seen = 1;
    end
    check("abort_no_done", 64'(done_seen), 64'd0);

    // Back-to-back: new request on the done cycle
    start_req(32'd100, 32'd7, FUNCT_DIVU);
    wait_done(lat, bc);
    check("b2b_first", dataOut, {32'd2, 32'd14});
    start_req(32'd3, 32'd10, FUNCT_DIVU);
    check("b2b_busy", 64'(busy), 64'd1);
    check("b2b_done", 64'(done), 64'd0);
    bc      = int'(busy);
    lat     = -1;
    changes = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (busy) bc++;
      if (done) begin
        lat = k;
        break;
      end
      if (dataOut !== {32'd2, 32'd14}) changes++;
    end
    check("b2b_held", 64'(changes), 64'd0);
    check("b2b_lat",  64'(lat),     64'd32);
    check("b2b_busy_len", 64'(bc),  64'd32);
    check("b2b_second", dataOut, {32'd3, 32'd0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
